// File: rtl/muladd_load_sched.sv
`default_nettype none
// ============================================================================
// Module      : muladd_load_sched
// Description : Load scheduler feeding the MulAdd_top load port. Sequences a
//               host valid/ready beat stream into per-layer vector loads with
//               a fixed compute gap between layers.
// Revision    : 1.0 - initial release
// ============================================================================
module muladd_load_sched #(
    parameter int DATA_W     = 32,
    parameter int BEATS_VEC  = 8,
    parameter int VECS_L0    = 32,
    parameter int VECS_LN    = 16,
    parameter int NUM_LAYERS = 8,
    parameter int GAP_CYC    = 24
) (
    input  logic              clk_data,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              host_valid_i,
    input  logic [DATA_W-1:0] host_payload_i,
    output logic              host_ready_o,
    output logic              load_en_o,
    output logic [DATA_W-1:0] load_payload_o,
    output logic [2:0]        layer_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int BEAT_W = (BEATS_VEC > 1) ? $clog2(BEATS_VEC) : 1;
    localparam int VEC_W  = $clog2((VECS_L0 > VECS_LN) ? VECS_L0 : VECS_LN);
    localparam int GAP_W  = $clog2(GAP_CYC + 1);

    localparam logic [BEAT_W-1:0] c_beat_last   = BEAT_W'(BEATS_VEC - 1);
    localparam logic [VEC_W-1:0]  c_vec_last_l0 = VEC_W'(VECS_L0 - 1);
    localparam logic [VEC_W-1:0]  c_vec_last_ln = VEC_W'(VECS_LN - 1);
    localparam logic [2:0]        c_layer_last  = 3'(NUM_LAYERS - 1);
    localparam logic [GAP_W-1:0]  c_gap_load    = GAP_W'(GAP_CYC);
    localparam logic [GAP_W-1:0]  c_gap_one     = GAP_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t              r_state;
    logic [BEAT_W-1:0]   r_beat;
    logic [VEC_W-1:0]    r_vec;
    logic [GAP_W-1:0]    r_gap;
    logic [2:0]          r_layer;
    logic                r_load_en;
    logic [DATA_W-1:0]   r_payload;

    logic [VEC_W-1:0]    w_vec_last;

    // Layer 0 interleaves input rows with weight columns, so it is twice as long.
    assign w_vec_last = (r_layer == 3'd0) ? c_vec_last_l0 : c_vec_last_ln;

    always_ff @(posedge clk_data or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_beat    <= '0;
            r_vec     <= '0;
            r_gap     <= '0;
            r_layer   <= '0;
            r_load_en <= 1'b0;
            r_payload <= '0;
        end else begin
            r_load_en <= 1'b0;
            if (abort_i) begin
                // Abort also suppresses the load of a beat accepted this cycle.
                r_state <= ST_IDLE;
                r_beat  <= '0;
                r_vec   <= '0;
                r_gap   <= '0;
                r_layer <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start_i) begin
                            r_state <= ST_LOAD;
                            r_beat  <= '0;
                            r_vec   <= '0;
                            r_layer <= '0;
                        end
                    end
                    ST_LOAD: begin
                        if (host_valid_i) begin
                            r_load_en <= 1'b1;
                            r_payload <= host_payload_i;
                            if (r_beat == c_beat_last) begin
                                r_beat <= '0;
                                if (r_vec == w_vec_last) begin
                                    r_vec <= '0;
                                    if (r_layer == c_layer_last) begin
                                        r_state <= ST_DONE;
                                    end else begin
                                        r_state <= ST_GAP;
                                        r_gap   <= c_gap_load;
                                    end
                                end else begin
                                    r_vec <= r_vec + 1'b1;
                                end
                            end else begin
                                r_beat <= r_beat + 1'b1;
                            end
                        end
                    end
                    ST_GAP: begin
                        // Leaving on count 1 gives exactly GAP_CYC not-ready cycles.
                        if (r_gap == c_gap_one) begin
                            r_gap   <= '0;
                            r_layer <= r_layer + 1'b1;
                            r_state <= ST_LOAD;
                        end else begin
                            r_gap <= r_gap - 1'b1;
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign host_ready_o   = (r_state == ST_LOAD);
    assign busy_o         = (r_state == ST_LOAD) || (r_state == ST_GAP);
    assign done_o         = (r_state == ST_DONE);
    assign load_en_o      = r_load_en;
    assign load_payload_o = r_payload;
    assign layer_o        = r_layer;

endmodule
`default_nettype wire

// File: tb/tb_muladd_load_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_muladd_load_sched
// Description : Directed self-checking bench for muladd_load_sched.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muladd_load_sched;

    logic        clk_data = 1'b0;
    logic        rst_n    = 1'b0;
    logic        start    = 1'b0;
    logic        abort    = 1'b0;
    logic        host_valid = 1'b0;
    logic [31:0] host_payload = '0;
    logic        host_ready;
    logic        load_en;
    logic [31:0] load_payload;
    logic [2:0]  layer;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    // Reference model: 0 IDLE, 1 LOAD, 2 GAP, 3 DONE
    int          m_ph    = 0;
    int          m_cnt   = 0;
    int          m_gap   = 0;
    int          m_layer = 0;
    bit          e_en    = 1'b0;
    logic [31:0] e_pl    = '0;

    always #5 clk_data = ~clk_data;

    muladd_load_sched dut (
        .clk_data       (clk_data),
        .rst_n          (rst_n),
        .start_i        (start),
        .abort_i        (abort),
        .host_valid_i   (host_valid),
        .host_payload_i (host_payload),
        .host_ready_o   (host_ready),
        .load_en_o      (load_en),
        .load_payload_o (load_payload),
        .layer_o        (layer),
        .busy_o         (busy),
        .done_o         (done)
    );

    task automatic model_reset();
        m_ph = 0; m_cnt = 0; m_gap = 0; m_layer = 0; e_en = 1'b0; e_pl = '0;
    endtask

    // Drive one cycle of inputs, advance the model, land #1 after the edge.
    task automatic model_step(input bit v, input bit st, input bit ab);
        host_valid   = v;
        host_payload = 32'(m_cnt);
        start        = st;
        abort        = ab;
        e_en         = 1'b0;
        if (ab) begin
            m_ph = 0; m_layer = 0; m_cnt = 0; m_gap = 0;
        end else begin
            case (m_ph)
                0: if (st) begin m_ph = 1; m_layer = 0; m_cnt = 0; end
                1: if (v) begin
                    e_en = 1'b1;
                    e_pl = 32'(m_cnt);
                    m_cnt++;
                    if (m_cnt == 1152) m_ph = 3;
                    else if (m_cnt >= 256 && ((m_cnt - 256) % 128) == 0) begin
                        m_ph = 2; m_gap = 24;
                    end
                end
                2: if (m_gap == 1) begin m_ph = 1; m_layer++; m_gap = 0; end
                   else m_gap--;
                default: m_ph = 0;
            endcase
        end
        @(posedge clk_data); #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_data);
        #1;
        checks += 6;
        if (load_en !== 1'b0)     begin errors++; $display("FAIL reset_load_en got %0b exp 0", load_en); end
        if (load_payload !== '0)  begin errors++; $display("FAIL reset_payload got %0h exp 0", load_payload); end
        if (host_ready !== 1'b0)  begin errors++; $display("FAIL reset_ready got %0b exp 0", host_ready); end
        if (layer !== 3'd0)       begin errors++; $display("FAIL reset_layer got %0d exp 0", layer); end
        if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        if (done !== 1'b0)        begin errors++; $display("FAIL reset_done got %0b exp 0", done); end
        rst_n = 1'b1;
        @(posedge clk_data); #1;
    endtask

    // Full job with host always valid; optional spurious starts in LOAD and GAP.
    task automatic test_full_job(input bit spurious);
        int n_en = 0, n_done = 0, n_gap = 0, n_gap1 = 0;
        bit l1_seen = 1'b0, fin = 1'b0, st;
        model_step(1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 3000; c++) begin
            checks += 5;
            if (host_ready !== (m_ph == 1)) begin errors++; $display("FAIL job_ready cnt=%0d got %0b exp %0b", m_cnt, host_ready, m_ph == 1); end
            if (load_en !== e_en) begin errors++; $display("FAIL job_load_en cnt=%0d got %0b exp %0b", m_cnt, load_en, e_en); end
            if (layer !== 3'(m_layer)) begin errors++; $display("FAIL job_layer cnt=%0d got %0d exp %0d", m_cnt, layer, m_layer); end
            if (busy !== (m_ph == 1 || m_ph == 2)) begin errors++; $display("FAIL job_busy cnt=%0d got %0b exp %0b", m_cnt, busy, m_ph == 1 || m_ph == 2); end
            if (done !== (m_ph == 3)) begin errors++; $display("FAIL job_done cnt=%0d got %0b exp %0b", m_cnt, done, m_ph == 3); end
            if (e_en) begin
                checks++;
                if (load_payload !== e_pl) begin errors++; $display("FAIL job_payload got %0d exp %0d", load_payload, e_pl); end
            end
            if (m_ph == 1 && m_cnt == 256 && !l1_seen) begin
                l1_seen = 1'b1;
                checks++;
                if (layer !== 3'd1) begin errors++; $display("FAIL beat256_layer got %0d exp 1", layer); end
            end
            n_en   += int'(load_en);
            n_done += int'(done);
            if (busy && !host_ready) n_gap++;
            if (busy && !host_ready && m_cnt == 256) n_gap1++;
            if (m_ph == 0) begin fin = 1'b1; break; end
            st = spurious && ((m_ph == 1 && m_cnt == 100) || (m_ph == 2 && m_gap == 10));
            model_step(1'b1, st, 1'b0);
        end
        checks += 5;
        if (!fin)          begin errors++; $display("FAIL job_timeout got unfinished exp finished"); end
        if (n_en != 1152)  begin errors++; $display("FAIL job_beats got %0d exp 1152", n_en); end
        if (n_done != 1)   begin errors++; $display("FAIL job_done_count got %0d exp 1", n_done); end
        if (n_gap != 168)  begin errors++; $display("FAIL job_gap_cycles got %0d exp 168", n_gap); end
        if (n_gap1 != 24)  begin errors++; $display("FAIL first_gap_len got %0d exp 24", n_gap1); end
    endtask

    task automatic test_bubbles();
        int n_en = 0;
        model_step(1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 1000 && m_ph == 1; c++) begin
            model_step(c[0] == 1'b0, 1'b0, 1'b0);
            checks++;
            if (load_en !== e_en) begin errors++; $display("FAIL bubble_load_en cycle=%0d got %0b exp %0b", c, load_en, e_en); end
            if (e_en) begin
                checks++;
                if (load_payload !== e_pl) begin errors++; $display("FAIL bubble_payload got %0d exp %0d", load_payload, e_pl); end
            end
            n_en += int'(load_en);
        end
        checks += 3;
        if (n_en != 256)         begin errors++; $display("FAIL bubble_beats got %0d exp 256", n_en); end
        if (host_ready !== 1'b0) begin errors++; $display("FAIL bubble_gap_ready got %0b exp 0", host_ready); end
        if (busy !== 1'b1)       begin errors++; $display("FAIL bubble_gap_busy got %0b exp 1", busy); end
        model_step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_abort();
        model_step(1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 2000 && m_cnt != 300; c++) model_step(1'b1, 1'b0, 1'b0);
        checks++;
        if (m_cnt != 300 || layer !== 3'd1) begin errors++; $display("FAIL abort_setup got layer %0d exp 1", layer); end
        model_step(1'b1, 1'b0, 1'b1);
        checks += 5;
        if (load_en !== 1'b0)    begin errors++; $display("FAIL abort_load_en got %0b exp 0", load_en); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL abort_busy got %0b exp 0", busy); end
        if (layer !== 3'd0)      begin errors++; $display("FAIL abort_layer got %0d exp 0", layer); end
        if (host_ready !== 1'b0) begin errors++; $display("FAIL abort_ready got %0b exp 0", host_ready); end
        if (done !== 1'b0)       begin errors++; $display("FAIL abort_done got %0b exp 0", done); end
        for (int c = 0; c < 4; c++) begin
            model_step(1'b1, 1'b0, 1'b0);
            checks++;
            if (done !== 1'b0 || load_en !== 1'b0) begin errors++; $display("FAIL abort_idle got done=%0b en=%0b exp 0 0", done, load_en); end
        end
        // Abort and start together in IDLE: abort wins.
        model_step(1'b1, 1'b1, 1'b1);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_start_idle got busy %0b exp 0", busy); end
        test_full_job(1'b0);
    endtask

    task automatic test_reset_mid_gap();
        model_step(1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 3000 && !(m_ph == 2 && m_layer == 3 && m_gap == 12); c++)
            model_step(1'b1, 1'b0, 1'b0);
        checks += 2;
        if (layer !== 3'd3 || host_ready !== 1'b0) begin errors++; $display("FAIL gap3_setup got layer %0d ready %0b exp 3 0", layer, host_ready); end
        if (busy !== 1'b1) begin errors++; $display("FAIL gap3_busy got %0b exp 1", busy); end
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (busy !== 1'b0 || layer !== 3'd0) begin errors++; $display("FAIL rst_async got busy %0b layer %0d exp 0 0", busy, layer); end
        if (load_payload !== '0) begin errors++; $display("FAIL rst_async_payload got %0h exp 0", load_payload); end
        if (load_en !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_async_en_done got %0b %0b exp 0 0", load_en, done); end
        repeat (2) @(posedge clk_data);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 6; c++) begin
            model_step(1'b1, 1'b0, 1'b0);
            checks++;
            if (host_ready !== 1'b0 || load_en !== 1'b0 || busy !== 1'b0)
                begin errors++; $display("FAIL post_rst_idle got ready=%0b en=%0b busy=%0b exp 0 0 0", host_ready, load_en, busy); end
        end
    endtask

    initial begin
        test_reset();
        test_full_job(1'b0);
        test_bubbles();
        test_abort();
        test_full_job(1'b1);
        test_reset_mid_gap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
